// File: rtl/net_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : net_accel_pkg
//  Brief    : Shared opcodes, reset actions and field-width helper for the
//             action lookup path.
//  Revision : 1.0 - initial release
// ============================================================================
package net_accel_pkg;

    localparam logic [1:0] OP_DROP   = 2'b00;
    localparam logic [1:0] OP_FWD    = 2'b01;
    localparam logic [1:0] OP_TO_CPU = 2'b10;
    localparam logic [1:0] OP_MIRROR = 2'b11;

    // Reset actions; the port field of both defaults is zero.
    localparam logic [1:0] RST_ENTRY_OP   = OP_DROP;
    localparam logic [1:0] RST_DEFAULT_OP = OP_TO_CPU;

    function automatic int action_width(input int port_w);
        return 2 + port_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/action_lookup_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : action_lookup_stage_if
//  Brief    : TCAM result stream in, forwarding action stream out.
//  Revision : 1.0 - initial release
// ============================================================================
interface action_lookup_stage_if #(
    parameter int IDX_W  = 4,
    parameter int PORT_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              in_hit;
    logic [IDX_W-1:0]  in_index;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_op;
    logic [PORT_W-1:0] out_port;
    logic              out_hit;
    logic [IDX_W-1:0]  out_index;

    modport master (
        output in_valid, in_hit, in_index, out_ready,
        input  in_ready, out_valid, out_op, out_port, out_hit, out_index
    );

    modport slave (
        input  in_valid, in_hit, in_index, out_ready,
        output in_ready, out_valid, out_op, out_port, out_hit, out_index
    );
endinterface
`default_nettype wire

// File: rtl/action_stats_counters.sv
`default_nettype none
// ============================================================================
//  Module   : action_stats_counters
//  Brief    : Per-entry saturating hit counters plus a miss counter.
//  Revision : 1.0 - initial release
// ============================================================================
module action_stats_counters #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc_hit,
    input  wire logic             inc_miss,
    input  wire logic [IDX_W-1:0] inc_index,
    input  wire logic [IDX_W-1:0] stat_addr,
    output logic      [CNT_W-1:0] hit_cnt,
    output logic      [CNT_W-1:0] miss_cnt
);
    localparam int c_depth = 2 ** IDX_W;

    logic [CNT_W-1:0] r_hit_cnt [c_depth];
    logic [CNT_W-1:0] r_miss_cnt;

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) r_hit_cnt[i] <= '0;
            r_miss_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < c_depth; i++) r_hit_cnt[i] <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (inc_hit && (r_hit_cnt[inc_index] != '1))
                r_hit_cnt[inc_index] <= r_hit_cnt[inc_index] + CNT_W'(1);
            if (inc_miss && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt  = r_hit_cnt[stat_addr];
    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: rtl/action_lookup_stage.sv
`default_nettype none
// ============================================================================
//  Module   : action_lookup_stage
//  Brief    : Maps TCAM hit/miss results to forwarding actions, one per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module action_lookup_stage
    import net_accel_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int PORT_W = 3,
    parameter int CNT_W  = 16
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    action_lookup_stage_if.slave     bus,
    input  wire logic                cfg_we,
    input  wire logic                cfg_default,
    input  wire logic [IDX_W-1:0]    cfg_addr,
    input  wire logic [2+PORT_W-1:0] cfg_wdata,
    input  wire logic [IDX_W-1:0]    stat_addr,
    output logic      [CNT_W-1:0]    stat_hit_cnt,
    output logic      [CNT_W-1:0]    stat_miss_cnt,
    input  wire logic                stat_clr
);
    localparam int c_depth = 2 ** IDX_W;
    localparam int c_act_w = action_width(PORT_W);

    logic [c_act_w-1:0] r_table [c_depth];
    logic [c_act_w-1:0] r_default;
    logic               r_out_valid;
    logic [c_act_w-1:0] r_out_act;
    logic               r_out_hit;
    logic [IDX_W-1:0]   r_out_index;

    logic               w_in_ready;
    logic               w_accept;
    logic [c_act_w-1:0] w_lookup;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    // Table reads see pre-edge contents, so a same-cycle write is not bypassed.
    assign w_lookup   = bus.in_hit ? r_table[bus.in_index] : r_default;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++)
                r_table[i] <= {RST_ENTRY_OP, {PORT_W{1'b0}}};
            r_default <= {RST_DEFAULT_OP, {PORT_W{1'b0}}};
        end else if (cfg_we) begin
            if (cfg_default) r_default         <= cfg_wdata;
            else             r_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_act   <= '0;
            r_out_hit   <= 1'b0;
            r_out_index <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_act   <= w_lookup;
            r_out_hit   <= bus.in_hit;
            r_out_index <= bus.in_index;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_out_act[c_act_w-1 -: 2];
    assign bus.out_port  = r_out_act[PORT_W-1:0];
    assign bus.out_hit   = r_out_hit;
    assign bus.out_index = r_out_index;

    action_stats_counters #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (stat_clr),
        .inc_hit   (w_accept && bus.in_hit),
        .inc_miss  (w_accept && !bus.in_hit),
        .inc_index (bus.in_index),
        .stat_addr (stat_addr),
        .hit_cnt   (stat_hit_cnt),
        .miss_cnt  (stat_miss_cnt)
    );

endmodule
`default_nettype wire

// File: doc/action_lookup_stage.md
Name: action_lookup_stage

Overview:
- Stage directly downstream of the TCAM-to-action pipeline register; consumes its (valid, hit, index) handshake stream.
- Resolves each TCAM result into a forwarding action: per-entry action table on hit, default action on miss.
- Presents the action on a registered valid/ready output toward the packet editor/egress.
- Keeps per-entry saturating hit counters and a miss counter, readable through a side stats port.

Parameters:
- IDX_W, 4, TCAM index width; table depth N = 2**IDX_W.
- PORT_W, 3, egress port field width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result valid (driven from action_valid)
- in_ready  out  1  stage can accept (drives action_ready)
- in_hit  in  1  TCAM hit flag
- in_index  in  IDX_W  matching entry index; ignored when in_hit=0
- out_valid  out  1  action result valid
- out_ready  in  1  downstream accepts
- out_op  out  2  action opcode: 00 DROP, 01 FWD, 10 TO_CPU, 11 MIRROR
- out_port  out  PORT_W  egress port
- out_hit  out  1  registered copy of in_hit
- out_index  out  IDX_W  registered copy of in_index
- cfg_we  in  1  table write strobe
- cfg_default  in  1  1: write the miss/default action; 0: write table[cfg_addr]
- cfg_addr  in  IDX_W  table entry to write
- cfg_wdata  in  2+PORT_W  {op, port}
- stat_addr  in  IDX_W  hit counter select
- stat_hit_cnt  out  CNT_W  hit counter[stat_addr], combinational read
- stat_miss_cnt  out  CNT_W  miss counter
- stat_clr  in  1  synchronous clear of all counters

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0; out_op, out_port, out_hit and out_index all 0.
  - All table entries = {DROP, 0}; default action = {TO_CPU, 0}.
  - All counters = 0.
- Handshake:
  - in_ready = !out_valid || out_ready, so the stage sustains full throughput, one result per cycle.
  - Accept happens when in_valid && in_ready.
- Latency: 1 cycle. On accept, the output registers load and out_valid=1 on the next edge.
  - in_hit=1: {out_op, out_port} = table[in_index].
  - in_hit=0: {out_op, out_port} = default action.
- Output hold and release:
  - When out_valid && !out_ready, all out_* hold stable.
  - out_valid clears only on out_valid && out_ready with no simultaneous accept.
  - Accept and output consume in the same cycle: load the new result, out_valid stays 1.
- Config writes:
  - A write on edge t affects lookups accepted from edge t+1.
  - A lookup accepted in the same cycle as a write to the same entry gets the old value (no bypass).
  - Writes are legal at any time, including while the output is stalled; a stalled output does not change.
- Statistics:
  - On accept with hit, hit_cnt[in_index] += 1; on accept with miss, miss_cnt += 1.
  - Counters saturate at 2**CNT_W-1; they never wrap.
  - stat_clr zeroes all counters. If it coincides with an accept, the clear wins and that increment is dropped.
- Reset mid-operation: any in-flight output result is discarded; the table and default action revert to reset values.
- in_index is don't-care on a miss and must not affect any hit counter.

Decomposition:
- Shared package (net_accel_pkg):
  - opcode constants OP_DROP, OP_FWD, OP_TO_CPU, OP_MIRROR.
  - reset defaults for table entries and the default action.
  - action field width helper (2+PORT_W).
- Natural sub-module: action_stats_counters. Holds the N+1 saturating counters, increment/clear logic and the read mux; the parent holds the table, the default register and the output register.

Test Plan:
- After reset: send hit, index 5 -> next cycle out_valid=1, op=DROP(00), port=0, out_index=5; stat_addr=5 gives hit count 1.
- Write table[3]={FWD, 6}; next cycle send hit, index 3 -> op=01, port=6. Write table[3]={MIRROR, 2} in the same cycle as a hit on 3 -> that result is {FWD, 6}; the following hit on 3 gives {MIRROR, 2}.
- Miss with in_index=7 -> op=TO_CPU, port=0; miss count 1; hit count[7] stays 0. Reprogram the default to {FWD, 1} via cfg_default -> the next miss yields {01, 1}.
- Back-to-back in_valid for 8 cycles with out_ready=1 -> 8 outputs on consecutive cycles, in_ready constantly 1. Drop out_ready for 3 cycles -> outputs held stable, in_ready=0, no counter increments during the stall.
- With CNT_W=4: 20 hits on index 0 -> count saturates at 15. stat_clr together with an accepted hit on 0 -> count=0 afterwards.
- Assert rst_n low while out_valid=1 and stalled -> out_valid=0 immediately; table[3] is back to {DROP, 0}; counters are 0.
